host_cmd_driver: RTL and testbench
==================================

Name: host_cmd_driver

Overview:
- Host-side initiator for the NPU MMIO command protocol.
- Accepts one command per valid/ready handshake. It writes the ARG, ADDR, CMD and MMVR registers, rings the doorbell, then polls STATUS until the busy bit clears.
- Returns the final status word on a response handshake. Sits between a testbench or embedded host sequencer and the control block's host_addr/host_wr_data/host_wr_en/host_rd_data port.

Parameters:
- HOST_DW, 32, host data width; equals HOST_DATA_WIDTH.
- MMIO_AW, 8, MMIO address width.
- CMD_W, 32, width of req_cmd; CMD_W <= HOST_DW.
- ADDR_W, 16, unified-buffer address width; ADDR_W <= HOST_DW.
- ARG_W, 32, argument width; ARG_W <= HOST_DW.
- BUF_W, 128, MMVR width; must be a multiple of HOST_DW. NBEATS = BUF_W/HOST_DW.
- REG_CMD, 0, CMD register offset.
- REG_ADDR, 1, ADDR register offset.
- REG_ARG, 2, ARG register offset.
- REG_MMVR, 3, MMVR base offset; beat k is written to REG_MMVR+k.
- REG_DOORBELL, 7, doorbell register offset; any write fires the doorbell.
- REG_STATUS, 8, STATUS register offset.
- BUSY_BIT, 0, index of the busy flag in STATUS.
- RD_LAT, 1, cycles from host_addr stable to host_rd_data valid; must be >= 0.
- HOLDOFF, 2, cycles after the doorbell write before the first status sample.
- TMO_CYC, 4096, poll timeout in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  command request valid.
- req_ready  out  1  high when in IDLE.
- req_cmd  in  CMD_W  command word.
- req_addr  in  ADDR_W  UB address.
- req_arg  in  ARG_W  argument.
- req_mmvr  in  BUF_W  MMVR payload.
- req_mmvr_en  in  1  1 = write the MMVR beats; 0 = skip them.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_status  out  HOST_DW  last sampled STATUS word.
- rsp_timeout  out  1  poll timed out (0 when the feature is absent).
- host_addr  out  MMIO_AW  MMIO address.
- host_wr_data  out  HOST_DW  MMIO write data.
- host_wr_en  out  1  MMIO write strobe, single cycle per register.
- host_rd_data  in  HOST_DW  MMIO read data.

Behaviour:
- Reset (rst high, asynchronous): state = IDLE.
  - host_wr_en = 0, host_addr = 0, host_wr_data = 0.
  - rsp_valid = 0, rsp_status = 0, rsp_timeout = 0.
  - req_ready = 1 (decoded from state).
  - All counters are cleared.
- All host-side outputs are registered.
- States: IDLE, WR_ARG, WR_ADDR, WR_CMD, WR_MMVR, WR_DB, HOLD, POLL, RESP.
- IDLE:
  - On req_valid && req_ready, latch all req_* fields and go to WR_ARG.
  - The accept cycle is T. The first host_wr_en is high in cycle T+1.
- Write sequence: one write per cycle, back to back, host_wr_en high for exactly one cycle each.
  - WR_ARG: host_addr = REG_ARG, data = arg zero-extended to HOST_DW.
  - WR_ADDR: host_addr = REG_ADDR, data = addr zero-extended.
  - WR_CMD: host_addr = REG_CMD, data = cmd zero-extended.
  - WR_MMVR (only if mmvr_en): NBEATS cycles, beat counter 0..NBEATS-1.
    - host_addr = REG_MMVR + k.
    - data = mmvr[k*HOST_DW +: HOST_DW], least-significant beat first.
    - The counter wraps to 0 on exit.
  - WR_DB: host_addr = REG_DOORBELL, data = 1.
- Doorbell timing: with mmvr_en = 0 the doorbell write is in cycle T+4; with mmvr_en = 1 it is in cycle T+4+NBEATS.
- HOLD: host_wr_en = 0, host_addr = REG_STATUS. Wait HOLDOFF cycles, then go to POLL.
- POLL:
  - host_addr is held at REG_STATUS.
  - A wait counter counts RD_LAT cycles, then host_rd_data is sampled into rsp_status.
  - If status[BUSY_BIT] = 1, restart the RD_LAT wait and resample.
  - If it is 0, go to RESP.
- RESP:
  - rsp_valid = 1; rsp_status and rsp_timeout are held stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE, clear rsp_valid and return host_addr to 0.
  - A new request is accepted no earlier than the following cycle.
- req_valid outside IDLE is ignored; req_ready stays 0. Latched fields are never updated mid-command.
- Reset mid-operation: all state is abandoned immediately, with no partial response. host_wr_en drops asynchronously.

Optional Feature:
- Macro HOST_CMD_DRIVER_TIMEOUT_EN.
- When defined:
  - A poll counter starts on entry to HOLD and increments every cycle through HOLD and POLL.
  - If it reaches TMO_CYC while busy is still set, go to RESP with rsp_timeout = 1 and rsp_status = last sample.
- When undefined: no counter, polling is unbounded, and rsp_timeout is tied to 0.

Test Plan:
- Reset: assert rst mid-WR_MMVR beat 2 -> host_wr_en = 0 in the same cycle. After release, the state is IDLE, req_ready = 1, rsp_valid = 0, and no further writes occur.
- Basic command: cmd = 0x5, addr = 0x0010, arg = 0x3, mmvr_en = 0. Status model reads busy for 3 samples, then 0x0.
  - Expected writes: ARG = 3 @ T+1, ADDR = 0x10 @ T+2, CMD = 5 @ T+3, DB = 1 @ T+4.
  - Then rsp_valid with rsp_status = 0.
- MMVR write: mmvr_en = 1, mmvr = 0x44444444_33333333_22222222_11111111.
  - Expected writes: addr 3 = 0x11111111, 4 = 0x22222222, 5 = 0x33333333, 6 = 0x44444444 on consecutive cycles.
  - Doorbell at T+8.
- Backpressure: hold rsp_ready = 0 for 10 cycles -> rsp_valid and rsp_status are stable, req_ready = 0, and req_valid pulses are ignored. After acceptance, req_ready = 1 the next cycle.
- Read latency: RD_LAT = 2, status changes from busy to 0x4 one cycle before the sample point -> rsp_status = 0x4. No sample is taken earlier than 2 cycles after host_addr = REG_STATUS.
- With HOST_CMD_DRIVER_TIMEOUT_EN and TMO_CYC = 16: busy held forever -> rsp_valid with rsp_timeout = 1 exactly 16 cycles after HOLD entry, rsp_status[BUSY_BIT] = 1.

Source files
------------

// File: rtl/host_cmd_driver.sv
// host_cmd_driver: host-side initiator for the NPU MMIO command protocol.
// Takes one command per req handshake, writes ARG/ADDR/CMD (and optionally the
// MMVR beats), rings the doorbell, polls STATUS until the busy bit clears and
// returns the final status word on the rsp handshake.
// Optional feature: define HOST_CMD_DRIVER_TIMEOUT_EN to bound the polling
// phase to TMO_CYC cycles and report rsp_timeout.
module host_cmd_driver #(
  parameter int unsigned HOST_DW      = 32,
  parameter int unsigned MMIO_AW      = 8,
  parameter int unsigned CMD_W        = 32,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned ARG_W        = 32,
  parameter int unsigned BUF_W        = 128,
  parameter int unsigned REG_CMD      = 0,
  parameter int unsigned REG_ADDR     = 1,
  parameter int unsigned REG_ARG      = 2,
  parameter int unsigned REG_MMVR     = 3,
  parameter int unsigned REG_DOORBELL = 7,
  parameter int unsigned REG_STATUS   = 8,
  parameter int unsigned BUSY_BIT     = 0,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned HOLDOFF      = 2,
  parameter int unsigned TMO_CYC      = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [CMD_W-1:0]   req_cmd,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [ARG_W-1:0]   req_arg,
  input  logic [BUF_W-1:0]   req_mmvr,
  input  logic               req_mmvr_en,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [HOST_DW-1:0] rsp_status,
  output logic               rsp_timeout,
  output logic [MMIO_AW-1:0] host_addr,
  output logic [HOST_DW-1:0] host_wr_data,
  output logic               host_wr_en,
  input  logic [HOST_DW-1:0] host_rd_data
);

  localparam int unsigned NBEATS = BUF_W / HOST_DW;
  localparam int unsigned BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int unsigned LAT_W  = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
  localparam int unsigned HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
`ifdef HOST_CMD_DRIVER_TIMEOUT_EN
  localparam int unsigned TMO_W  = $clog2(TMO_CYC + 1);
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_WR_ARG, S_WR_ADDR, S_WR_CMD, S_WR_MMVR, S_WR_DB, S_HOLD, S_POLL, S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_state_d;
  logic [BEAT_W-1:0]   r_beat, w_beat_d;
  logic [HOLD_W-1:0]   r_hold, w_hold_d;
  logic [LAT_W-1:0]    r_wait, w_wait_d;
`ifdef HOST_CMD_DRIVER_TIMEOUT_EN
  logic [TMO_W-1:0]    r_tmo, w_tmo_d;
`endif

  // Latched command fields (ARG is consumed directly on the accept edge)
  logic [CMD_W-1:0]    r_cmd;
  logic [ADDR_W-1:0]   r_addr;
  logic [HOST_DW-1:0]  r_mmvr_beats [NBEATS];
  logic                r_mmvr_en;

  logic                r_req_ready, w_req_ready_d;
  logic                r_rsp_valid, w_rsp_valid_d;
  logic [HOST_DW-1:0]  r_rsp_status, w_rsp_status_d;
  logic                r_rsp_timeout, w_rsp_timeout_d;
  logic [MMIO_AW-1:0]  r_host_addr, w_host_addr_d;
  logic [HOST_DW-1:0]  r_host_wr_data, w_host_wr_data_d;
  logic                r_host_wr_en, w_host_wr_en_d;
  logic                w_accept;

  assign w_accept     = (r_state == S_IDLE) && req_valid;
  assign req_ready    = r_req_ready;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_status   = r_rsp_status;
  assign host_addr    = r_host_addr;
  assign host_wr_data = r_host_wr_data;
  assign host_wr_en   = r_host_wr_en;
`ifdef HOST_CMD_DRIVER_TIMEOUT_EN
  assign rsp_timeout  = r_rsp_timeout;
`else
  assign rsp_timeout  = 1'b0;
`endif

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
      r_hold  <= '0;
      r_wait  <= '0;
`ifdef HOST_CMD_DRIVER_TIMEOUT_EN
      r_tmo   <= '0;
`endif
    end else begin
      r_state <= w_state_d;
      r_beat  <= w_beat_d;
      r_hold  <= w_hold_d;
      r_wait  <= w_wait_d;
`ifdef HOST_CMD_DRIVER_TIMEOUT_EN
      r_tmo   <= w_tmo_d;
`endif
    end
  end

  // Next state, counters, and next values of the registered outputs
  always_comb begin
    w_state_d       = r_state;
    w_beat_d        = r_beat;
    w_hold_d        = r_hold;
    w_wait_d        = r_wait;
`ifdef HOST_CMD_DRIVER_TIMEOUT_EN
    w_tmo_d         = r_tmo;
`endif
    w_rsp_status_d  = r_rsp_status;
    w_rsp_timeout_d = r_rsp_timeout;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_d       = S_WR_ARG;
          w_rsp_timeout_d = 1'b0;
        end
      end
      S_WR_ARG:  w_state_d = S_WR_ADDR;
      S_WR_ADDR: w_state_d = S_WR_CMD;
      S_WR_CMD:  w_state_d = r_mmvr_en ? S_WR_MMVR : S_WR_DB;
      S_WR_MMVR: begin
        if (r_beat == BEAT_W'(NBEATS - 1)) begin
          w_beat_d  = '0;
          w_state_d = S_WR_DB;
        end else begin
          w_beat_d  = r_beat + BEAT_W'(1);
        end
      end
      S_WR_DB: begin
        w_hold_d  = '0;
        w_wait_d  = '0;
`ifdef HOST_CMD_DRIVER_TIMEOUT_EN
        w_tmo_d   = '0;
`endif
        w_state_d = (HOLDOFF == 0) ? S_POLL : S_HOLD;
      end
      S_HOLD: begin
        if (r_hold == HOLD_W'(HOLDOFF - 1)) begin
          w_hold_d  = '0;
          w_state_d = S_POLL;
        end else begin
          w_hold_d  = r_hold + HOLD_W'(1);
        end
      end
      S_POLL: begin
        // Sample once the read data has had RD_LAT cycles to settle
        if (r_wait == LAT_W'(RD_LAT)) begin
          w_wait_d       = '0;
          w_rsp_status_d = host_rd_data;
          if (!host_rd_data[BUSY_BIT]) begin
            w_state_d = S_RESP;
          end
        end else begin
          w_wait_d = r_wait + LAT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_d = S_IDLE;
        end
      end
      default: w_state_d = S_IDLE;
    endcase

`ifdef HOST_CMD_DRIVER_TIMEOUT_EN
    // Poll budget covers HOLD and POLL; a clean sample on the last cycle wins
    if (r_state == S_HOLD || r_state == S_POLL) begin
      w_tmo_d = r_tmo + TMO_W'(1);
      if ((r_tmo == TMO_W'(TMO_CYC - 1)) && (w_state_d != S_RESP)) begin
        w_state_d       = S_RESP;
        w_rsp_timeout_d = 1'b1;
      end
    end
`endif

    w_req_ready_d    = (w_state_d == S_IDLE);
    w_rsp_valid_d    = (w_state_d == S_RESP);
    w_host_wr_en_d   = 1'b0;
    w_host_addr_d    = '0;
    w_host_wr_data_d = '0;
    case (w_state_d)
      S_WR_ARG: begin
        w_host_wr_en_d   = 1'b1;
        w_host_addr_d    = MMIO_AW'(REG_ARG);
        w_host_wr_data_d = HOST_DW'(req_arg);
      end
      S_WR_ADDR: begin
        w_host_wr_en_d   = 1'b1;
        w_host_addr_d    = MMIO_AW'(REG_ADDR);
        w_host_wr_data_d = HOST_DW'(r_addr);
      end
      S_WR_CMD: begin
        w_host_wr_en_d   = 1'b1;
        w_host_addr_d    = MMIO_AW'(REG_CMD);
        w_host_wr_data_d = HOST_DW'(r_cmd);
      end
      S_WR_MMVR: begin
        w_host_wr_en_d   = 1'b1;
        w_host_addr_d    = MMIO_AW'(REG_MMVR) + MMIO_AW'(w_beat_d);
        w_host_wr_data_d = r_mmvr_beats[w_beat_d];
      end
      S_WR_DB: begin
        w_host_wr_en_d   = 1'b1;
        w_host_addr_d    = MMIO_AW'(REG_DOORBELL);
        w_host_wr_data_d = HOST_DW'(1);
      end
      S_HOLD, S_POLL, S_RESP: begin
        w_host_addr_d    = MMIO_AW'(REG_STATUS);
      end
      default: begin
        w_host_addr_d    = '0;
      end
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_ready    <= 1'b1;
      r_rsp_valid    <= 1'b0;
      r_rsp_status   <= '0;
      r_rsp_timeout  <= 1'b0;
      r_host_addr    <= '0;
      r_host_wr_data <= '0;
      r_host_wr_en   <= 1'b0;
    end else begin
      r_req_ready    <= w_req_ready_d;
      r_rsp_valid    <= w_rsp_valid_d;
      r_rsp_status   <= w_rsp_status_d;
      r_rsp_timeout  <= w_rsp_timeout_d;
      r_host_addr    <= w_host_addr_d;
      r_host_wr_data <= w_host_wr_data_d;
      r_host_wr_en   <= w_host_wr_en_d;
    end
  end

  // Command field capture on accept; never touched mid-command
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd     <= '0;
      r_addr    <= '0;
      r_mmvr_en <= 1'b0;
      for (int k = 0; k < NBEATS; k++) begin
        r_mmvr_beats[k] <= '0;
      end
    end else if (w_accept) begin
      r_cmd     <= req_cmd;
      r_addr    <= req_addr;
      r_mmvr_en <= req_mmvr_en;
      for (int k = 0; k < NBEATS; k++) begin
        r_mmvr_beats[k] <= req_mmvr[k*HOST_DW +: HOST_DW];
      end
    end
  end

endmodule

// File: tb/tb_host_cmd_driver.sv
// Self-checking bench for host_cmd_driver: table vectors, a reset corner case
// and randomized commands against a cycle-level arithmetic reference model.
module tb_host_cmd_driver;

  localparam int unsigned RD_LAT  = 2;
  localparam int unsigned HOLDOFF = 2;
  localparam int unsigned TMO_CYC = 16;
  localparam int unsigned NBEATS  = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [31:0]  req_cmd = '0;
  logic [15:0]  req_addr = '0;
  logic [31:0]  req_arg = '0;
  logic [127:0] req_mmvr = '0;
  logic         req_mmvr_en = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [31:0]  rsp_status;
  logic         rsp_timeout;
  logic [7:0]   host_addr;
  logic [31:0]  host_wr_data;
  logic         host_wr_en;
  logic [31:0]  host_rd_data;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_err = 0;
  int          busy_until = 0;
  logic [31:0] busy_word = 32'h1;
  logic [31:0] done_word = 32'h0;

  typedef struct {
    logic [31:0]  cmd;
    logic [15:0]  addr;
    logic [31:0]  arg;
    logic [127:0] mmvr;
    logic         en;
    logic [31:0]  busy_word;
    logic [31:0]  done_word;
    int           busy_len;
    int           rdy_dly;
    int           exp_db_off;
    int           exp_rsp_off;
    logic [31:0]  exp_status;
    logic         exp_tmo;
  } vec_t;

  vec_t tbl [6];

  host_cmd_driver #(.RD_LAT(RD_LAT), .HOLDOFF(HOLDOFF), .TMO_CYC(TMO_CYC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_addr(req_addr), .req_arg(req_arg),
    .req_mmvr(req_mmvr), .req_mmvr_en(req_mmvr_en),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_timeout(rsp_timeout),
    .host_addr(host_addr), .host_wr_data(host_wr_data), .host_wr_en(host_wr_en),
    .host_rd_data(host_rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Device STATUS model: busy until an absolute cycle, then the final word
  always_comb host_rd_data = (cyc < busy_until) ? busy_word : done_word;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Issue one command and check every cycle against the reference timeline
  task automatic run_cmd(input vec_t v, output int db_off, output int rsp_off,
                         output logic [31:0] st, output logic tmo);
    int t, nwr, d, h, p, s, r, e, i;
    logic [7:0]  wa [12];
    logic [31:0] wd [12];
    logic        exp_tmo;
    logic [31:0] exp_st;
    db_off = -1; rsp_off = -1; st = '0; tmo = 1'b0;
    @(negedge clk);
    t = cyc;
    chk("req_ready_idle", req_ready, 1);
    req_cmd = v.cmd; req_addr = v.addr; req_arg = v.arg;
    req_mmvr = v.mmvr; req_mmvr_en = v.en; req_valid = 1'b1; rsp_ready = 1'b0;
    wa[0] = 8'd2; wd[0] = v.arg;
    wa[1] = 8'd1; wd[1] = {16'h0, v.addr};
    wa[2] = 8'd0; wd[2] = v.cmd;
    nwr = 3;
    if (v.en) begin
      for (int k = 0; k < NBEATS; k++) begin
        wa[nwr] = 8'(3 + k);
        wd[nwr] = v.mmvr[k*32 +: 32];
        nwr++;
      end
    end
    wa[nwr] = 8'd7; wd[nwr] = 32'd1; nwr++;
    d = t + nwr;           // doorbell cycle
    h = d + 1;             // first holdoff cycle
    p = h + HOLDOFF;       // first poll cycle
    busy_word = v.busy_word; done_word = v.done_word;
    busy_until = d + 1 + v.busy_len;
    s = p + RD_LAT;
    while (s < busy_until) s += RD_LAT + 1;
    r = s + 1; exp_tmo = 1'b0; exp_st = v.done_word;
`ifdef HOST_CMD_DRIVER_TIMEOUT_EN
    if (s > h + TMO_CYC - 1) begin
      r = h + TMO_CYC; exp_tmo = 1'b1; exp_st = v.busy_word;
    end
`endif
    e = r + v.rdy_dly;     // last RESP cycle
    for (int c = t + 1; c <= e + 1; c++) begin
      @(negedge clk);
      i = c - t - 1;
      if (i < nwr) begin
        chk("wr_en", host_wr_en, 1);
        chk("wr_addr", host_addr, wa[i]);
        chk("wr_data", host_wr_data, wd[i]);
      end else begin
        chk("wr_en_quiet", host_wr_en, 0);
      end
      if (c > d && c < r) chk("status_addr", host_addr, 8);
      chk("rsp_valid", rsp_valid, (c >= r && c <= e));
      chk("req_ready", req_ready, (c == e + 1));
      if (c >= r && c <= e) begin
        chk("rsp_status", rsp_status, exp_st);
        chk("rsp_timeout", rsp_timeout, exp_tmo);
      end
      if (c == e + 1) chk("idle_addr", host_addr, 0);
      if (host_wr_en && host_addr == 8'd7 && db_off < 0) db_off = c - t;
      if (rsp_valid && rsp_off < 0) begin
        rsp_off = c - t; st = rsp_status; tmo = rsp_timeout;
      end
      if (c <= e) begin
        req_valid = 1'($urandom_range(0, 1));
        req_cmd = $urandom; req_addr = 16'($urandom); req_arg = $urandom;
        req_mmvr = {$urandom, $urandom, $urandom, $urandom};
        req_mmvr_en = 1'($urandom_range(0, 1));
      end else begin
        req_valid = 1'b0;
      end
      rsp_ready = (c < r) ? 1'($urandom_range(0, 1)) : (c == e);
    end
  endtask

  // Reset asserted during the third MMVR beat
  task automatic reset_mid_mmvr();
    int t;
    @(negedge clk);
    t = cyc;
    req_cmd = 32'h9; req_addr = 16'h0040; req_arg = 32'h1; req_mmvr_en = 1'b1;
    req_mmvr = 128'h44444444_33333333_22222222_11111111; req_valid = 1'b1;
    busy_until = t + 1000;
    repeat (6) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    chk("rst_pre_wr_en", host_wr_en, 1);
    chk("rst_pre_addr", host_addr, 5);
    chk("rst_pre_data", host_wr_data, 32'h33333333);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_wr_en", host_wr_en, 0);
    chk("rst_async_addr", host_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_rel_req_ready", req_ready, 1);
    chk("rst_rel_rsp_valid", rsp_valid, 0);
    repeat (12) begin
      @(negedge clk);
      chk("rst_quiet_wr_en", host_wr_en, 0);
      chk("rst_quiet_ready", req_ready, 1);
      chk("rst_quiet_rsp", rsp_valid, 0);
    end
  endtask

  initial begin
    int db_off, rsp_off;
    logic [31:0] st;
    logic tmo;
    vec_t rv;

    // cmd, addr, arg, mmvr, en, busy_word, done_word, busy_len, rdy_dly,
    // exp_db_off, exp_rsp_off, exp_status, exp_tmo
    tbl[0] = '{32'h5, 16'h0010, 32'h3, 128'h0, 1'b0, 32'h0000_0001, 32'h0,
               13, 0, 4, 19, 32'h0, 1'b0};
    tbl[1] = '{32'h7, 16'h0123, 32'hDEAD_BEEF, 128'h44444444_33333333_22222222_11111111,
               1'b1, 32'h0000_0003, 32'hA5A5_0000, 0, 2, 8, 14, 32'hA5A5_0000, 1'b0};
    tbl[2] = '{32'h2, 16'h00F0, 32'h8, 128'h0, 1'b0, 32'h0000_0001, 32'h4,
               7, 1, 4, 13, 32'h4, 1'b0};
    tbl[3] = '{32'h2, 16'h00F1, 32'h9, 128'h0, 1'b0, 32'h0000_0001, 32'h4,
               8, 0, 4, 16, 32'h4, 1'b0};
    tbl[4] = '{32'h1234_5678, 16'hFFFF, 32'h0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
               1'b1, 32'h8000_0001, 32'h1234_0000, 2, 10, 8, 14, 32'h1234_0000, 1'b0};
`ifdef HOST_CMD_DRIVER_TIMEOUT_EN
    tbl[5] = '{32'h3, 16'h0002, 32'h5, 128'h0, 1'b0, 32'h0000_0BB1, 32'h0000_00F0,
               100, 1, 4, 21, 32'h0000_0BB1, 1'b1};
`else
    tbl[5] = '{32'h3, 16'h0002, 32'h5, 128'h0, 1'b0, 32'h0000_0BB1, 32'h0000_00F0,
               100, 1, 4, 106, 32'h0000_00F0, 1'b0};
`endif

    repeat (2) @(negedge clk);
    chk("reset_req_ready", req_ready, 1);
    chk("reset_wr_en", host_wr_en, 0);
    chk("reset_addr", host_addr, 0);
    chk("reset_wr_data", host_wr_data, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_status", rsp_status, 0);
    chk("reset_rsp_timeout", rsp_timeout, 0);
    rst = 1'b0;

    for (int n = 0; n < 6; n++) begin
      run_cmd(tbl[n], db_off, rsp_off, st, tmo);
      chk($sformatf("tbl%0d_db_off", n), db_off, tbl[n].exp_db_off);
      chk($sformatf("tbl%0d_rsp_off", n), rsp_off, tbl[n].exp_rsp_off);
      chk($sformatf("tbl%0d_status", n), st, tbl[n].exp_status);
      chk($sformatf("tbl%0d_timeout", n), tmo, tbl[n].exp_tmo);
    end

    reset_mid_mmvr();

    for (int n = 0; n < 20; n++) begin
      rv.cmd = $urandom; rv.addr = 16'($urandom); rv.arg = $urandom;
      rv.mmvr = {$urandom, $urandom, $urandom, $urandom};
      rv.en = 1'($urandom_range(0, 1));
      rv.busy_word = $urandom | 32'h1;
      rv.done_word = $urandom & ~32'h1;
      rv.busy_len = int'($urandom_range(0, 40));
      rv.rdy_dly = int'($urandom_range(0, 5));
      rv.exp_db_off = 0; rv.exp_rsp_off = 0; rv.exp_status = '0; rv.exp_tmo = 1'b0;
      run_cmd(rv, db_off, rsp_off, st, tmo);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
